// File: rtl/inst_fetch.sv
// ============================================================================
// inst_fetch
//   Instruction-fetch stage feeding the IF/ID pipeline register. It fetches
//   one 32-bit little-endian instruction one byte per cycle over a shared
//   8-bit memory port, presents it with its PC, and holds it while IF/ID is
//   stalled. A branch/jump from EX redirects the PC and flushes any partly
//   assembled instruction.
//
//   Ports
//     clk              clock, rising edge
//     rst              asynchronous reset, active low
//     rdy              global run enable (low = frozen, no memory request)
//     stall_i          IF/ID will not capture this edge
//     branch_i         one-cycle redirect pulse from EX
//     branch_target_i  redirect PC
//     mem_grant_i      arbiter serves this cycle's fetch request
//     mem_data_i       byte for the address granted in the previous cycle
//     mem_req_o        fetch requests the memory port
//     mem_addr_o       requested byte address (pc + issue_idx)
//     if_pc/if_inst    presented instruction and its PC
//     if_valid         if_pc/if_inst hold a complete instruction
//
//   Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module inst_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              mem_grant_i,
  input  logic [7:0]        mem_data_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_inst,
  output logic              if_valid
);

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [2:0]        issue_idx, issue_n;
  logic [2:0]        recv_idx, recv_n;
  logic              rx_pend, rx_pend_n;
  logic [23:0]       shift_buf, buf_n;
  logic [ADDR_W-1:0] if_pc_n;
  logic [31:0]       if_inst_n;
  logic              if_valid_n;

  // Request is gated by reset as well so the port is quiet while held in reset.
  assign mem_req_o  = rst & rdy & (state == S_ISSUE);
  assign mem_addr_o = pc + {{(ADDR_W-3){1'b0}}, issue_idx};

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    issue_n    = issue_idx;
    recv_n     = recv_idx;
    rx_pend_n  = 1'b0;
    buf_n      = shift_buf;
    if_pc_n    = if_pc;
    if_inst_n  = if_inst;
    if_valid_n = if_valid;

    if (branch_i) begin
      // Redirect wins over everything, including a capture in HOLD. Any
      // byte granted this cycle is orphaned by leaving rx_pend_n low.
      pc_n       = branch_target_i;
      state_n    = S_ISSUE;
      issue_n    = 3'd0;
      recv_n     = 3'd0;
      if_valid_n = 1'b0;
    end else begin
      rx_pend_n = mem_req_o & mem_grant_i;

      // Bytes 0..2 are buffered; byte 3 goes straight into if_inst below.
      if (rx_pend) begin
        case (recv_idx)
          3'd0:    buf_n[7:0]   = mem_data_i;
          3'd1:    buf_n[15:8]  = mem_data_i;
          3'd2:    buf_n[23:16] = mem_data_i;
          default: ;
        endcase
        recv_n = recv_idx + 3'd1;
      end

      case (state)
        S_ISSUE: begin
          if (mem_grant_i) begin
            issue_n = issue_idx + 3'd1;
            if (issue_idx == 3'd3) state_n = S_WAIT;
          end
        end
        S_WAIT: begin
          if (rx_pend && (recv_idx == 3'd3)) begin
            if_inst_n  = {mem_data_i, shift_buf};
            if_pc_n    = pc;
            if_valid_n = 1'b1;
            state_n    = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            pc_n       = pc + {{(ADDR_W-3){1'b0}}, 3'd4};
            issue_n    = 3'd0;
            recv_n     = 3'd0;
            if_valid_n = 1'b0;
            state_n    = S_ISSUE;
          end
        end
        default: state_n = S_ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_ISSUE;
      pc        <= RESET_PC;
      issue_idx <= 3'd0;
      recv_idx  <= 3'd0;
      rx_pend   <= 1'b0;
      shift_buf <= '0;
      if_pc     <= '0;
      if_inst   <= '0;
      if_valid  <= 1'b0;
    end else if (rdy) begin
      state     <= state_n;
      pc        <= pc_n;
      issue_idx <= issue_n;
      recv_idx  <= recv_n;
      rx_pend   <= rx_pend_n;
      shift_buf <= buf_n;
      if_pc     <= if_pc_n;
      if_inst   <= if_inst_n;
      if_valid  <= if_valid_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none

module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        mem_grant_i;
  logic [7:0]  mem_data_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:1023];

  inst_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .stall_i         (stall_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .mem_grant_i     (mem_grant_i),
    .mem_data_i      (mem_data_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .if_valid        (if_valid)
  );

  always #5 clk = ~clk;

  // Memory: data for a granted address appears the next cycle, held otherwise.
  always @(posedge clk) begin
    if (mem_req_o && mem_grant_i) mem_data_i <= mem[mem_addr_o[9:0]];
  end

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] a1, a2, a3;
    a1 = a + 32'd1; a2 = a + 32'd2; a3 = a + 32'd3;
    return {mem[a3[9:0]], mem[a2[9:0]], mem[a1[9:0]], mem[a[9:0]]};
  endfunction

  task automatic test_reset();
    rst = 1'b0; rdy = 1'b1; stall_i = 1'b0; branch_i = 1'b0;
    branch_target_i = '0; mem_grant_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0 || mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b pc=%h inst=%h req=%b expected 0/0/0/0",
               if_valid, if_pc, if_inst, mem_req_o);
    end
  endtask

  // Fetch at pc 0 with grant held: issues cycles 0-3, visible cycle 5.
  task automatic test_basic();
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      rst = 1'b1; mem_grant_i = 1'b1; stall_i = 1'b0;
      #1;
      checks++;
      if (k < 4) begin
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'(k)) begin
          errors++;
          $display("FAIL basic_issue c%0d: req=%b addr=%h expected 1/%h", k, mem_req_o, mem_addr_o, k);
        end
      end else if (k == 4) begin
        if (mem_req_o !== 1'b0 || if_valid !== 1'b0) begin
          errors++;
          $display("FAIL basic_wait: req=%b valid=%b expected 0/0", mem_req_o, if_valid);
        end
      end else begin
        if (if_valid !== 1'b1 || if_inst !== 32'h0050_0013 || if_pc !== 32'h0) begin
          errors++;
          $display("FAIL basic_done: valid=%b inst=%h pc=%h expected 1/00500013/0", if_valid, if_inst, if_pc);
        end
      end
    end
  endtask

  // Fetch at pc 4; stall held cycles 5-7, capture at end of cycle 8.
  task automatic test_stall();
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      mem_grant_i = 1'b1; stall_i = (k >= 5 && k <= 7);
      #1;
      checks++;
      if (k < 4) begin
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'(4 + k)) begin
          errors++;
          $display("FAIL stall_issue c%0d: req=%b addr=%h expected 1/%h", k, mem_req_o, mem_addr_o, 4 + k);
        end
      end else if (k == 4) begin
        if (if_valid !== 1'b0) begin
          errors++;
          $display("FAIL stall_wait: valid=%b expected 0", if_valid);
        end
      end else begin
        if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_inst !== word_at(32'h4) || mem_req_o !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold c%0d: valid=%b pc=%h inst=%h req=%b expected 1/4/%h/0",
                   k, if_valid, if_pc, if_inst, mem_req_o, word_at(32'h4));
        end
      end
    end
  endtask

  // Fetch at pc 8; grant withheld in cycles 1-2.
  task automatic test_grant_gap();
    logic [31:0] exp_a [0:5];
    exp_a = '{32'h8, 32'h9, 32'h9, 32'h9, 32'hA, 32'hB};
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      mem_grant_i = !(k == 1 || k == 2); stall_i = 1'b0;
      #1;
      checks++;
      if (k <= 5) begin
        if (mem_req_o !== 1'b1 || mem_addr_o !== exp_a[k]) begin
          errors++;
          $display("FAIL gap_issue c%0d: req=%b addr=%h expected 1/%h", k, mem_req_o, mem_addr_o, exp_a[k]);
        end
      end else if (k == 6) begin
        if (if_valid !== 1'b0 || mem_req_o !== 1'b0) begin
          errors++;
          $display("FAIL gap_wait: valid=%b req=%b expected 0/0", if_valid, mem_req_o);
        end
      end else begin
        if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_inst !== word_at(32'h8)) begin
          errors++;
          $display("FAIL gap_done: valid=%b pc=%h inst=%h expected 1/8/%h", if_valid, if_pc, if_inst, word_at(32'h8));
        end
      end
    end
  endtask

  // Fetch at pc 12; branch to 0x100 in the cycle byte 2 is granted.
  task automatic test_branch();
    logic [31:0] exp_a [0:6];
    exp_a = '{32'hC, 32'hD, 32'hE, 32'h100, 32'h101, 32'h102, 32'h103};
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      mem_grant_i = 1'b1; stall_i = 1'b0;
      branch_i = (k == 2); branch_target_i = 32'h100;
      #1;
      checks++;
      if (k <= 6) begin
        if (mem_req_o !== 1'b1 || mem_addr_o !== exp_a[k]) begin
          errors++;
          $display("FAIL branch_issue c%0d: req=%b addr=%h expected 1/%h", k, mem_req_o, mem_addr_o, exp_a[k]);
        end
      end else if (k == 7) begin
        if (if_valid !== 1'b0 || mem_req_o !== 1'b0) begin
          errors++;
          $display("FAIL branch_wait: valid=%b req=%b expected 0/0", if_valid, mem_req_o);
        end
      end else begin
        if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_inst !== word_at(32'h100)) begin
          errors++;
          $display("FAIL branch_done: valid=%b pc=%h inst=%h expected 1/100/%h", if_valid, if_pc, if_inst, word_at(32'h100));
        end
      end
    end
    branch_i = 1'b0;
  endtask

  // Fetch at pc 0x104; rdy low in cycles 2-5 shifts completion by 4.
  task automatic test_rdy_freeze();
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      mem_grant_i = 1'b1; stall_i = 1'b0; rdy = !(k >= 2 && k <= 5);
      #1;
      checks++;
      if (k <= 1 || k == 6 || k == 7) begin
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h104 + 32'(k <= 1 ? k : k - 4)) begin
          errors++;
          $display("FAIL rdy_issue c%0d: req=%b addr=%h", k, mem_req_o, mem_addr_o);
        end
      end else if (k <= 5 || k == 8) begin
        if (mem_req_o !== 1'b0 || if_valid !== 1'b0) begin
          errors++;
          $display("FAIL rdy_frozen c%0d: req=%b valid=%b expected 0/0", k, mem_req_o, if_valid);
        end
      end else begin
        if (if_valid !== 1'b1 || if_pc !== 32'h104 || if_inst !== word_at(32'h104)) begin
          errors++;
          $display("FAIL rdy_done: valid=%b pc=%h inst=%h expected 1/104/%h", if_valid, if_pc, if_inst, word_at(32'h104));
        end
      end
    end
    rdy = 1'b1;
  endtask

  // Fetch at pc 0x108; async reset pulse during WAIT, refetch from 0,
  // then a second pulse while the refetched instruction is held.
  task automatic test_async_reset();
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      mem_grant_i = 1'b1; stall_i = 1'b0;
      #1;
    end
    checks++;
    if (mem_req_o !== 1'b0 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_prewait: req=%b valid=%b expected 0/0", mem_req_o, if_valid);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (if_valid !== 1'b0 || mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL areset_during: valid=%b req=%b expected 0/0", if_valid, mem_req_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL areset_restart: req=%b addr=%h expected 1/0", mem_req_o, mem_addr_o);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      mem_grant_i = 1'b1; stall_i = 1'b1;
      #1;
      if (k == 5) begin
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'h0050_0013) begin
          errors++;
          $display("FAIL areset_refetch: valid=%b pc=%h inst=%h expected 1/0/00500013", if_valid, if_pc, if_inst);
        end
      end
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0) begin
      errors++;
      $display("FAIL areset_hold: valid=%b pc=%h inst=%h expected 0/0/0", if_valid, if_pc, if_inst);
    end
    rst = 1'b1;
    stall_i = 1'b0;
  endtask

  // Random grant/stall/rdy/branch against a transaction-level model that
  // only counts granted bytes per fetch and tracks the expected PC.
  task automatic test_random();
    logic [31:0] exp_pc;
    int          n;
    bit          inflight, exp_valid, exp_req;
    int          completed;
    exp_pc = 32'h0; n = 0; inflight = 0; exp_valid = 0; completed = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i != 0) @(negedge clk);
      rdy         = ($urandom_range(0, 99) < 85);
      mem_grant_i = ($urandom_range(0, 99) < 75);
      stall_i     = ($urandom_range(0, 1) == 1);
      branch_i    = ($urandom_range(0, 99) < 4);
      branch_target_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3))) : $urandom;
      #1;
      exp_req = rdy && !exp_valid && (n < 4);
      checks++;
      if (mem_req_o !== exp_req) begin
        errors++;
        $display("FAIL rand_req i%0d: req=%b expected %b", i, mem_req_o, exp_req);
      end
      if (exp_req) begin
        checks++;
        if (mem_addr_o !== exp_pc + 32'(n)) begin
          errors++;
          $display("FAIL rand_addr i%0d: addr=%h expected %h", i, mem_addr_o, exp_pc + 32'(n));
        end
      end
      checks++;
      if (if_valid !== exp_valid) begin
        errors++;
        $display("FAIL rand_valid i%0d: valid=%b expected %b", i, if_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (if_pc !== exp_pc || if_inst !== word_at(exp_pc)) begin
          errors++;
          $display("FAIL rand_inst i%0d: pc=%h inst=%h expected %h/%h", i, if_pc, if_inst, exp_pc, word_at(exp_pc));
        end
      end
      // Model update for the coming edge.
      if (rdy) begin
        if (branch_i) begin
          exp_pc = branch_target_i; n = 0; inflight = 0; exp_valid = 0;
        end else if (exp_valid) begin
          if (!stall_i) begin
            exp_valid = 0; exp_pc = exp_pc + 32'd4; n = 0; completed++;
          end
        end else if (inflight) begin
          inflight = 0; exp_valid = 1;
        end else if (mem_grant_i) begin
          n++;
          if (n == 4) inflight = 1;
        end
      end
    end
    checks++;
    if (completed < 20) begin
      errors++;
      $display("FAIL rand_progress: completed=%0d expected at least 20", completed);
    end
    branch_i = 1'b0; rdy = 1'b1;
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h50; mem[3] = 8'h00;
    test_reset();
    test_basic();
    test_stall();
    test_grant_gap();
    test_branch();
    test_rdy_freeze();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
